im_fetch_ctrl: RTL
==================

// Module: im_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the 128x32 asynchronous-read instruction memory.
//  - Owns the PC and drives the word address into the memory.
//  - Registers the returned word into a one-entry valid/ready output stage toward decode.
//  - Applies taken-branch and jump redirects, and halts after the last program word.
//  - Sits between the instruction memory and the decode/control stage of the MIPS core.
// PARAMETERS
//  AW        7        word-address width (memory depth 2**AW)
//  DW        32       instruction width
//  RESET_PC  7'd0     PC loaded on reset and on every start
//  LAST_PC   7'd20    word index of the last program instruction; HALT follows its issue
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous reset, active low
//  start        in   1      IDLE/HALT -> RUN; PC <= RESET_PC; ignored in RUN
//  im_addr      out  AW     word address to instruction memory; always equals pc
//  im_data      in   DW     combinational read data for im_addr
//  instr        out  DW     registered instruction word
//  instr_pc     out  AW     word address of instr
//  instr_valid  out  1      instr/instr_pc are valid
//  instr_ready  in   1      decode accepts instr this cycle (accept = valid & ready)
//  br_taken     in   1      instr is a taken beq; qualified by accept
//  br_off       in   16     signed word offset of that beq (low AW bits used)
//  jmp          in   1      instr is j; qualified by accept
//  jmp_idx      in   26     jump target word index (low AW bits used)
//  halted       out  1      high in HALT
//  retired      out  16     accepted-instruction count, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (rst_n==0 at an edge, any state, mid-stall included):
//  - state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, retired=0.
//  States (2-bit): IDLE=0, RUN=1, HALT=2.
//  IDLE:
//  - No fetch occurs.
//  - start -> RUN with pc=RESET_PC.
//  RUN, load condition: load = !instr_valid | instr_ready.
//  - On load: instr<=im_data; instr_pc<=pc; instr_valid<=1; pc<=pc+1 (mod 2**AW, 127->0).
//  - No load (valid & !ready): instr, instr_pc, instr_valid and pc all hold (stall).
//  Redirect: evaluated only on accept; otherwise br_taken/jmp are ignored.
//  - jmp: target = jmp_idx[AW-1:0].
//  - Else br_taken: target = instr_pc + 1 + br_off[AW-1:0] (mod 2**AW).
//  - jmp has priority when both are high.
//  - On redirect: pc<=target; instr_valid<=0. The word fetched this cycle is squashed,
//    giving exactly one bubble. The next valid instruction has instr_pc=target.
//  Halt:
//  - When a load in RUN issues pc==LAST_PC: state<=HALT and no further loads occur.
//  - A redirect on that same edge overrides: stay in RUN at target.
//  HALT:
//  - halted=1; instr_valid holds until accepted, then drops to 0. im_addr is stable.
//  - A redirect accepted on the last word -> RUN at target, halted<=0.
//  - start -> RUN, pc=RESET_PC, instr_valid<=0.
//  retired: +1 on every accept in any state, saturating.
//  Latency: start at edge N -> first valid instr at edge N+1. Full throughput is one
//  word per cycle while instr_ready=1.
// STRUCTURE
//  fetch_pkg:
//  - fetch_state_t enum {IDLE, RUN, HALT}.
//  - Constants: OP_BEQ=6'b000100, OP_J=6'b000010, OP_LW=6'b100011, OP_SW=6'b101011,
//    OP_RTYPE=6'b000000.
//  Sub-module fetch_next_pc (combinational): computes target and the next pc from
//  pc, instr_pc, br_off, jmp_idx and the redirect selects.
//  Top level: state register, pc, output stage and retired counter.
// TESTING
//  1 reset; start=1 for one cycle; ready=1 -> instr_pc 0,1,2.. on consecutive edges;
//    im_addr leads instr_pc by 1; retired increments every cycle.
//  2 ready=0 for 3 cycles with instr_pc=4 -> instr, instr_pc=4 and im_addr=5 are stable;
//    ready=1 -> next instr_pc=5; no word is dropped or duplicated.
//  3 accept at instr_pc=7 with br_taken=1, br_off=1 -> one cycle with instr_valid=0,
//    then instr_pc=9.
//  4 accept at instr_pc=8 with jmp=1, jmp_idx=13 -> one bubble, then instr_pc=13.
//    Repeat with br_taken=1 also high -> still 13.
//  5 run to instr_pc=20 and accept it -> halted=1, instr_valid=0, im_addr=21 held;
//    start -> instr_pc=0 one edge later; jmp_idx=127 then sequential -> 127 then 0.
//  6 rst_n=0 for one edge during a stall -> all outputs at reset values next cycle;
//    a start pulse while in RUN has no effect.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and opcode constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;

  // True for opcodes this core implements; decode uses it to flag illegal words.
  function automatic logic op_is_known(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_J) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_RTYPE);
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: sequential increment, or a jump/branch target when decode
// accepts a redirecting instruction.
module fetch_next_pc #(
  parameter int AW = 7
) (
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] instr_pc,
  input  logic [15:0]   br_off,
  input  logic [25:0]   jmp_idx,
  input  logic          jmp_sel,
  input  logic          br_sel,
  output logic [AW-1:0] target,
  output logic [AW-1:0] pc_next
);

  // Only the low AW bits address the memory; the upper bits wrap away.
  logic unused_hi_bits;
  assign unused_hi_bits = ^{br_off[15:AW], jmp_idx[25:AW]};

  always_comb begin
    target  = jmp_sel ? jmp_idx[AW-1:0] : (instr_pc + AW'(1) + br_off[AW-1:0]);
    pc_next = (jmp_sel || br_sel) ? target : (pc + AW'(1));
  end

endmodule

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, registers memory words into a
// one-entry valid/ready stage, applies redirects and halts after the last word.
module im_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int            AW       = 7,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = 7'd0,
  parameter logic [AW-1:0] LAST_PC  = 7'd20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] im_addr,
  input  logic [DW-1:0] im_data,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          br_taken,
  input  logic [15:0]   br_off,
  input  logic          jmp,
  input  logic [25:0]   jmp_idx,
  output logic          halted,
  output logic [15:0]   retired
);

  fetch_state_t  state_reg;
  logic [AW-1:0] pc_reg;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] target;
  logic          accept;
  logic          load;
  logic          redirect;

  assign accept   = instr_valid & instr_ready;
  assign load     = ~instr_valid | instr_ready;
  assign redirect = accept & (jmp | br_taken);
  assign im_addr  = pc_reg;

  fetch_next_pc #(.AW(AW)) u_next_pc (
    .pc       (pc_reg),
    .instr_pc (instr_pc),
    .br_off   (br_off),
    .jmp_idx  (jmp_idx),
    .jmp_sel  (accept & jmp),
    .br_sel   (accept & br_taken),
    .target   (target),
    .pc_next  (pc_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      retired     <= '0;
    end else begin
      if (accept && (retired != 16'hFFFF)) begin
        retired <= retired + 16'd1;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            pc_reg    <= RESET_PC;
          end
        end
        RUN: begin
          // A redirect squashes the word fetched this cycle, leaving one bubble.
          if (redirect) begin
            pc_reg      <= pc_next;
            instr_valid <= 1'b0;
          end else if (load) begin
            instr       <= im_data;
            instr_pc    <= pc_reg;
            instr_valid <= 1'b1;
            pc_reg      <= pc_next;
            if (pc_reg == LAST_PC) begin
              state_reg <= HALT;
              halted    <= 1'b1;
            end
          end
        end
        HALT: begin
          if (start) begin
            state_reg   <= RUN;
            pc_reg      <= RESET_PC;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
          end else if (redirect) begin
            state_reg   <= RUN;
            pc_reg      <= pc_next;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
          end else if (accept) begin
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule
